// File: rtl/ysyx_23060096_wbu_if.sv
// Writeback input channels: ALU result and load result, each a
// valid/ready handshake carrying a destination register and its data.
// master = producing stage (EXU/LSU side), slave = writeback unit.
interface ysyx_23060096_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready
  );
endinterface

// File: rtl/ysyx_23060096_wbu.sv
// Writeback unit: arbitrates ALU/LSU result packets (LSU has priority),
// registers the winner and writes it to the register file one cycle later,
// keeps a pending-write scoreboard for decode hazard checks and counts
// retired packets. A hold request freezes the registered packet.
// Optional build macro YSYX_23060096_WBU_FWD_EN adds write-port forwarding
// (rs1_fwd/rs2_fwd) and clears rsN_busy for a register being written now.
module ysyx_23060096_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  ysyx_23060096_wbu_if.slave    up,
  input  logic                  hold,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
`ifdef YSYX_23060096_WBU_FWD_EN
  output logic [DATA_WIDTH-1:0] rs1_fwd,
  output logic [DATA_WIDTH-1:0] rs2_fwd,
`endif
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [31:0]           retire_cnt
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic                  lsu_rdy;
  logic                  alu_rdy;
  logic                  lsu_acc;
  logic                  alu_acc;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_load;
  logic                  wb_drop;
  logic                  wr_fire;

  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_set;
  logic [NREG-1:0]       busy_clr;
  logic [NREG-1:0]       busy_nxt;

  // Fixed-priority arbitration: LSU first, nothing accepted in reset or HOLD.
  always_comb begin
    lsu_rdy      = rstn && !hold && (state != HOLD);
    alu_rdy      = lsu_rdy && !up.lsu_valid;
    up.lsu_ready = lsu_rdy;
    up.alu_ready = alu_rdy;
    lsu_acc      = up.lsu_valid && lsu_rdy;
    alu_acc      = up.alu_valid && alu_rdy;
    accept       = lsu_acc || alu_acc;
    sel_rd       = lsu_acc ? up.lsu_rd   : up.alu_rd;
    sel_data     = lsu_acc ? up.lsu_data : up.alu_data;
  end

  // Next-state and packet-register control.
  // A hold seen while in WRITE suppresses the write and parks the packet,
  // so it is written exactly once, after hold has dropped.
  always_comb begin
    state_nxt = state;
    wb_load   = 1'b0;
    wb_drop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WRITE;
          wb_load   = 1'b1;
        end
      end
      WRITE: begin
        if (hold) begin
          state_nxt = HOLD;
        end else if (accept) begin
          state_nxt = WRITE;
          wb_load   = 1'b1;
        end else begin
          state_nxt = IDLE;
          wb_drop   = 1'b1;
        end
      end
      HOLD: begin
        if (!hold) begin
          state_nxt = WRITE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered writeback packet.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (wb_load) begin
      wb_valid <= 1'b1;
      wb_rd    <= sel_rd;
      wb_data  <= sel_data;
    end else if (wb_drop) begin
      wb_valid <= 1'b0;
    end
  end

  // Register-file write port; rd=0 packets retire without writing.
  always_comb begin
    wr_fire  = wb_valid && (state == WRITE) && !hold;
    rf_wen   = rstn && wr_fire && (wb_rd != '0);
    rf_waddr = rstn ? wb_rd   : '0;
    rf_wdata = rstn ? wb_data : '0;
  end

  // Scoreboard set/clear masks; set is applied last so it wins on collision.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_en && (issue_rd != '0)) begin
      busy_set[issue_rd] = 1'b1;
    end
    if (rf_wen) begin
      busy_clr[rf_waddr] = 1'b1;
    end
    busy_nxt    = (busy & ~busy_clr) | busy_set;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Retired-packet counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      retire_cnt <= '0;
    end else if (accept) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

`ifdef YSYX_23060096_WBU_FWD_EN
  logic fwd_hit1;
  logic fwd_hit2;

  // Source lookup with bypass: a register written this cycle is not busy
  // unless decode re-marks it in the same cycle.
  always_comb begin
    fwd_hit1 = rf_wen && (rf_waddr == rs1) &&
               !(issue_en && (issue_rd != '0) && (issue_rd == rs1));
    fwd_hit2 = rf_wen && (rf_waddr == rs2) &&
               !(issue_en && (issue_rd != '0) && (issue_rd == rs2));
    rs1_busy = rstn && busy[rs1] && !fwd_hit1;
    rs2_busy = rstn && busy[rs2] && !fwd_hit2;
    rs1_fwd  = rf_wdata;
    rs2_fwd  = rf_wdata;
  end
`else
  // Source lookup straight from the registered scoreboard.
  always_comb begin
    rs1_busy = rstn && busy[rs1];
    rs2_busy = rstn && busy[rs2];
  end
`endif

endmodule

// File: doc/ysyx_23060096_wbu.md
YSYX_23060096_WBU -- requirements
Module: ysyx_23060096_wbu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 alu_valid / alu_ready / alu_rd / alu_data  in/out/in/in  1/1/ADDR_WIDTH/DATA_WIDTH  ALU result channel.
REQ-006 lsu_valid / lsu_ready / lsu_rd / lsu_data  in/out/in/in  1/1/ADDR_WIDTH/DATA_WIDTH  load result channel.
REQ-007 hold  in  1  writeback freeze request (debug/difftest stall).
REQ-008 issue_en / issue_rd  in/in  1/ADDR_WIDTH  decode marks rd as pending.
REQ-009 rs1 / rs2  in  ADDR_WIDTH  source registers being checked by decode.
REQ-010 rs1_busy / rs2_busy  out  1  source has a pending write.
REQ-011 rf_wen / rf_waddr / rf_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  register-file write port.
REQ-012 retire_cnt  out  32  count of accepted writeback packets.

Function
REQ-013 Transfer on a channel SHALL occur when valid && ready in the same cycle.
REQ-014 Arbitration fixed: lsu_ready = !hold && state!=HOLD; alu_ready = lsu_ready && !lsu_valid (LSU wins).
REQ-015 At most one packet SHALL be accepted per cycle; the rejected ALU packet keeps valid/rd/data stable (upstream rule).
REQ-016 Accepted packet SHALL be registered into wb_valid/wb_rd/wb_data; rf_wen asserts exactly one cycle after acceptance (latency 1).
REQ-017 rf_wen = wb_valid && wb_rd!=0 && state==WRITE; rd=0 packets are accepted and retired but never written.
REQ-018 States: IDLE (no packet), WRITE (wb_valid, driving port), HOLD (packet held, port idle).
REQ-019 IDLE->WRITE on accept; WRITE->WRITE on accept same cycle (back-to-back, 1 packet/cycle); WRITE->IDLE no accept; any state with hold=1 and packet registered ->HOLD; HOLD->WRITE when hold drops.
REQ-020 In HOLD, rf_wen=0, wb_* unchanged, both ready=0; write SHALL occur on the first cycle after hold deasserts.
REQ-021 Scoreboard busy[2^ADDR_WIDTH-1:0]: issue_en && issue_rd!=0 sets bit; rf_wen clears bit rf_waddr.
REQ-022 Set and clear of the same index in one cycle: set wins.
REQ-023 busy[0] SHALL be constant 0; rs1_busy = busy[rs1], rs2_busy = busy[rs2] (combinational from registered bits).
REQ-024 retire_cnt SHALL increment by 1 on every accept, wrap 0xFFFFFFFF->0.

Reset
REQ-025 While rstn=0 at posedge: state=IDLE, wb_valid=0, wb_rd=0, wb_data=0, busy=0, retire_cnt=0.
REQ-026 Reset outputs: rf_wen=0, rf_waddr=0, rf_wdata=0, rs1_busy=rs2_busy=0, both ready=0 during reset cycle.
REQ-027 Reset mid-operation SHALL drop any registered or held packet without writing it; no accept in the reset cycle.

Configuration
REQ-028 Macro YSYX_23060096_WBU_FWD_EN SHALL gate write-port forwarding.
REQ-029 Defined: outputs rs1_fwd / rs2_fwd (DATA_WIDTH) = rf_wdata; rsN_busy forced 0 when rf_wen && rf_waddr==rsN (unless issue sets it same cycle).
REQ-030 Undefined: no rsN_fwd ports; rsN_busy follows REQ-023 only, decode stalls one extra cycle.

Verification
REQ-031 Reset, issue_en rd=5, ALU valid rd=5 data=0x1234 -> next cycle rf_wen=1 waddr=5 wdata=0x1234; busy[5] clear after; retire_cnt=1.
REQ-032 ALU rd=3 and LSU rd=4 valid same cycle -> LSU accepted, alu_ready=0; writes rd=4 then rd=3 on consecutive cycles.
REQ-033 hold=1 for 3 cycles after accept of rd=7 data=0xA5A5A5A5 -> rf_wen=0 for 3 cycles, ready=0, write occurs cycle after hold drops.
REQ-034 ALU rd=0 data=0xFFFFFFFF -> rf_wen stays 0, retire_cnt increments; issue_rd=0 -> rs1_busy=0 for rs1=0.
REQ-035 busy[9]=1, rf_wen rd=9 and issue_en rd=9 same cycle -> busy[9] stays 1; with FWD_EN rs1=9 sees rs1_busy=1.
REQ-036 rstn=0 while in HOLD with packet rd=2 -> no write ever issued, busy=0, retire_cnt=0.
